// File: rtl/uart_tx_ng_pkg.sv
// Shared types and helpers for the uart_tx_ng transmitter: line configuration,
// word-length encoding, FSM states and the parity rule.
package uart_tx_ng_pkg;

  localparam int MAX_BITS = 9;

  typedef enum logic [2:0] {
    wls_5bits = 3'd0,
    wls_6bits = 3'd1,
    wls_7bits = 3'd2,
    wls_8bits = 3'd3,
    wls_9bits = 3'd4
  } wls_t;

  typedef struct packed {
    wls_t wls;
    logic pen;
    logic eps;
    logic stick_parity;
    logic stb;
    logic set_break;
    logic afe;
  } tx_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int wls_bits(input wls_t w);
    return 5 + int'(w);
  endfunction

  // eps=0 gives odd parity, eps=1 even; stick parity forces the bit to ~eps.
  function automatic logic parity_bit(input logic [MAX_BITS-1:0] data, input wls_t wls,
                                      input logic eps, input logic stick);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < wls_bits(wls)) x ^= data[i];
    end
    if (stick) return ~eps;
    return eps ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_tx_ng.sv
// UART transmitter: start, 5..9 data bits LSB first, optional parity, 1/1.5/2
// stop bits, paced by an external baud tick with OVS ticks per bit.
module uart_tx_ng
  import uart_tx_ng_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              baudout_i,
  input  tx_cfg_t           cfg_i,
  input  logic              cts_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              sr_empty_o,
  output logic              frame_done_o,
  output logic              sout_o
);

  localparam int TW = $clog2(2 * OVS);
  localparam logic [TW-1:0] TICK_BIT = TW'(OVS - 1);

  tx_state_t         state_q;
  logic [TW-1:0]     tick_q;
  logic [TW-1:0]     stop_ld_q;
  logic [3:0]        bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic              pen_q;
  logic              par_q;
  logic              sout_q;
  logic              sout_o_q;
  logic              sr_empty_q;
  logic              done_q;
  logic              rdy_q;
  logic              xfer;
  logic              tick_end;

  function automatic logic [3:0] frame_bits(input wls_t w);
    int n;
    n = wls_bits(w);
    if (n > DATA_W) n = DATA_W;
    return 4'(n);
  endfunction

  // Tick preload for the stop phase; counter counts down to zero inclusive.
  function automatic logic [TW-1:0] stop_ticks(input tx_cfg_t c);
    if (!c.stb) return TW'(OVS - 1);
    if (c.wls == wls_5bits) return TW'(3 * OVS / 2 - 1);
    return TW'(2 * OVS - 1);
  endfunction

  assign tx_ready_o   = rdy_q & (~cfg_i.afe | cts_i);
  assign xfer         = tx_valid_i & tx_ready_o;
  assign tick_end     = baudout_i & (tick_q == '0);
  assign sr_empty_o   = sr_empty_q;
  assign frame_done_o = done_q;
  assign sout_o       = sout_o_q;

  // Frame payload and per-frame settings, held from acceptance to frame end.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      shreg_q   <= tx_data_i;
      pen_q     <= cfg_i.pen;
      stop_ld_q <= stop_ticks(cfg_i);
      par_q     <= parity_bit(MAX_BITS'(tx_data_i), cfg_i.wls, cfg_i.eps, cfg_i.stick_parity);
    end else if (state_q == DATA && tick_end) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      sout_q     <= 1'b1;
      sout_o_q   <= 1'b1;
      sr_empty_q <= 1'b1;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      sout_o_q <= sout_q & ~cfg_i.set_break;
      done_q   <= 1'b0;
      if (baudout_i && tick_q != '0) tick_q <= tick_q - TW'(1);
      case (state_q)
        IDLE: begin
          rdy_q <= ~xfer;
          if (xfer) begin
            state_q    <= START;
            tick_q     <= TICK_BIT;
            bit_q      <= frame_bits(cfg_i.wls) - 4'd1;
            sout_q     <= 1'b0;
            sr_empty_q <= 1'b0;
          end
        end
        START: if (tick_end) begin
          state_q <= DATA;
          tick_q  <= TICK_BIT;
          sout_q  <= shreg_q[0];
        end
        DATA: if (tick_end) begin
          if (bit_q == '0) begin
            if (pen_q) begin
              state_q <= PARITY;
              tick_q  <= TICK_BIT;
              sout_q  <= par_q;
            end else begin
              state_q <= STOP;
              tick_q  <= stop_ld_q;
              sout_q  <= 1'b1;
            end
          end else begin
            bit_q  <= bit_q - 4'd1;
            tick_q <= TICK_BIT;
            sout_q <= shreg_q[1];
            // The shift register drains as the final data bit goes out.
            if (bit_q == 4'd1) sr_empty_q <= 1'b1;
          end
        end
        PARITY: if (tick_end) begin
          state_q <= STOP;
          tick_q  <= stop_ld_q;
          sout_q  <= 1'b1;
        end
        STOP: if (tick_end) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          rdy_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_ng.md
UART_TX_NG -- requirements
Module: uart_tx_ng

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, range 5..9, giving the maximum data bits per frame.
REQ-002 The block SHALL have parameter OVS, default 16, range 4..32, giving baud ticks per bit.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port baudout_i, input, 1 bit: one-cycle baud tick enable.
REQ-006 The block SHALL have port cfg_i, input, tx_cfg_t: wls (5..DATA_W), pen, eps, stick_parity, stb, set_break, afe.
REQ-007 The block SHALL have port cts_i, input, 1 bit: clear-to-send, active high, used only when afe=1.
REQ-008 The block SHALL have port tx_data_i, input, DATA_W bits: frame data, LSB transmitted first.
REQ-009 The block SHALL have port tx_valid_i, input, 1 bit: source holds data.
REQ-010 The block SHALL have port tx_ready_o, output, 1 bit: block accepts data this cycle.
REQ-011 The block SHALL have port sr_empty_o, output, 1 bit: shift register empty.
REQ-012 The block SHALL have port frame_done_o, output, 1 bit: one-cycle pulse at the end of the stop bit(s).
REQ-013 The block SHALL have port sout_o, output, 1 bit: registered serial output.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; the bit counter and tick counter SHALL decrement only on baudout_i.
REQ-015 tx_ready_o SHALL be high only in IDLE with (afe=0 or cts_i=1); a transfer SHALL occur when tx_valid_i and tx_ready_o are both high, on any clk_i cycle, and SHALL not depend on baudout_i.
REQ-016 On transfer, the block SHALL latch tx_data_i and cfg_i for the whole frame (later cfg_i changes take effect next frame; set_break excepted), clear sr_empty_o, drive internal sout=0, load the tick counter with OVS-1 and enter START.
REQ-017 START, each DATA bit and PARITY SHALL each last exactly OVS baud ticks.
REQ-018 DATA SHALL shift out wls bits LSB first; data bits above wls SHALL be ignored; sr_empty_o SHALL set when the last data bit begins.
REQ-019 Parity SHALL be computed over the wls bits: eps=0 odd, eps=1 even; with stick_parity=1 the parity bit SHALL be ~eps; PARITY SHALL be skipped when pen=0.
REQ-020 STOP SHALL drive 1 for OVS ticks (stb=0), 3*OVS/2 ticks (stb=1 with wls=5), or 2*OVS ticks (stb=1 otherwise).
REQ-021 At the final tick of STOP, the block SHALL pulse frame_done_o and return to IDLE; a frame accepted in that IDLE cycle SHALL start with no idle gap.
REQ-022 When afe=1 and cts_i=0, no new frame SHALL start; a frame in progress SHALL complete unaffected.
REQ-023 sout_o SHALL equal the previous cycle's (internal sout AND NOT cfg_i.set_break); break SHALL not stall the FSM.
REQ-024 The tick counter SHALL be $clog2(2*OVS) bits wide and SHALL never wrap during a phase.

Reset
REQ-025 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, sout_o=1, internal sout=1, tx_ready_o=0, sr_empty_o=1, frame_done_o=0 and counters=0; the data register SHALL not be reset.
REQ-026 Reset asserted mid-frame SHALL abort the frame; sout_o SHALL be 1 the cycle after reset, and there SHALL be no frame_done_o pulse.

Structure
REQ-027 Package uart_tx_ng_pkg SHALL hold tx_cfg_t, the wls_t enum (wls_5bits..wls_9bits), the state enum, and a parity function parametrised by wls.
REQ-028 The block SHALL be a single module with no sub-modules; the tick counter is inline.

Verification
REQ-029 The bench SHALL cover: OVS=16, wls=8, pen=0, stb=0, data 0x55 -> sout_o 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks, then frame_done_o pulses once.
REQ-030 The bench SHALL cover: DATA_W=9, wls=9, pen=1, eps=1, data 0x1FF -> 9 ones followed by parity 1, with stop.
REQ-031 The bench SHALL cover: wls=5, stb=1, OVS=16 -> stop lasts 24 ticks; with wls=7, stb=1 -> stop lasts 32 ticks.
REQ-032 The bench SHALL cover: valid held continuously over two words -> second start bit follows the stop bit with 0 idle ticks; cfg_i changed mid-frame -> current frame unchanged.
REQ-033 The bench SHALL cover: afe=1, cts_i=0 with valid asserted -> tx_ready_o=0 and sout_o=1; on cts_i=1 -> frame starts; set_break pulse mid-frame -> sout_o=0 for that duration and frame_done_o timing unchanged.
REQ-034 The bench SHALL cover: rst_i asserted during DATA -> next cycle sout_o=1, sr_empty_o=1, tx_ready_o=0, and there is no frame_done_o pulse.
